mac_tx_framer: RTL

//  Ethernet MAC transmit framer: consumes a byte stream (dest..payload, no FCS) and emits a GMII-style

---
 rtl/mac_pkg.sv | 42 ++++
 rtl/mac_crc_tx.sv | 32 +++
 rtl/mac_tx_framer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types, constants and bit helpers for the MAC transmit path.
package mac_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StSfd,
    StPayload,
    StPad,
    StFcs,
    StIfg
  } mac_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_SEED      = 32'hFFFF_FFFF;

  function automatic logic [7:0] bitrev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = d[31-i];
    return r;
  endfunction

  // MSB-first CRC-32 step over one byte (bit 7 enters first).
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_crc_tx.sv
// CRC-32 accumulator, one byte per enabled cycle, non-reflected register form.
module mac_crc_tx
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_init,
  input  logic        crc_en,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] r_crc;
  logic [31:0] w_crc_next;

  // Next CRC value if the current byte is folded in.
  always_comb begin
    w_crc_next = crc32_byte(r_crc, data_in);
  end

  // CRC register: seeded on reset, advanced on each enabled byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc <= crc_init ? CRC_SEED : 32'h0;
    end else if (crc_en) begin
      r_crc <= w_crc_next;
    end
  end

  assign crc_out = r_crc;

endmodule

// File: rtl/mac_tx_framer.sv
// Ethernet TX framer: preamble/SFD, payload, zero pad, FCS, inter-frame gap.
// Every output byte is registered one cycle after the state that decides it,
// so the state register runs one byte ahead of txd.
module mac_tx_framer
  import mac_pkg::*;
#(
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned PRE_LEN = 7,
  parameter int unsigned IFG_LEN = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] txd,
  output logic       tx_en,
  output logic       tx_er
);

  localparam logic [16:0] MinLen17 = 17'(MIN_LEN);
  localparam logic [15:0] PreLen16 = 16'(PRE_LEN);
  localparam logic [15:0] IfgLen16 = 16'(IFG_LEN);

  mac_state_e  r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_byte_cnt;
  logic [31:0] r_fcs;

  logic [16:0] w_cnt_next;
  logic [15:0] w_byte_cnt_inc;
  logic        w_crc_rst;
  logic        w_crc_en;
  logic [7:0]  w_crc_din;
  logic [31:0] w_crc_out;
  logic [31:0] w_fcs;

  assign s_ready = (r_state == StPayload);

  // Byte count after the byte being registered now; unsaturated copy for compares.
  always_comb begin
    w_cnt_next     = {1'b0, r_byte_cnt} + 17'd1;
    w_byte_cnt_inc = (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;
  end

  // CRC is restarted during SFD and fed each payload/pad byte as it is registered.
  always_comb begin
    w_crc_rst = rst | (r_state == StSfd);
    w_crc_en  = ((r_state == StPayload) && s_valid) || (r_state == StPad);
    w_crc_din = bitrev8((r_state == StPayload) ? s_data : 8'h00);
    w_fcs     = ~bitrev32(w_crc_out);
  end

  mac_crc_tx u_crc (
    .clk      (clk),
    .rst      (w_crc_rst),
    .crc_init (1'b1),
    .crc_en   (w_crc_en),
    .data_in  (w_crc_din),
    .crc_out  (w_crc_out)
  );

  // Framing FSM with registered txd/tx_en/tx_er.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= 16'd0;
      r_byte_cnt <= 16'd0;
      r_fcs      <= 32'h0;
      txd        <= 8'h00;
      tx_en      <= 1'b0;
      tx_er      <= 1'b0;
    end else begin
      tx_er <= 1'b0;
      unique case (r_state)
        StIdle: begin
          txd   <= 8'h00;
          tx_en <= 1'b0;
          if (s_valid) begin
            txd     <= PREAMBLE_BYTE;
            tx_en   <= 1'b1;
            r_cnt   <= 16'd1;
            r_state <= (PreLen16 > 16'd1) ? StPre : StSfd;
          end
        end
        StPre: begin
          txd   <= PREAMBLE_BYTE;
          tx_en <= 1'b1;
          r_cnt <= r_cnt + 16'd1;
          if (r_cnt + 16'd1 >= PreLen16) r_state <= StSfd;
        end
        StSfd: begin
          txd        <= SFD_BYTE;
          tx_en      <= 1'b1;
          r_byte_cnt <= 16'd0;
          r_state    <= StPayload;
        end
        StPayload: begin
          r_cnt <= 16'd0;
          if (s_valid) begin
            txd        <= s_data;
            tx_en      <= 1'b1;
            r_byte_cnt <= w_byte_cnt_inc;
            if (s_last) r_state <= (w_cnt_next < MinLen17) ? StPad : StFcs;
          end else begin
            // Underrun: abandon the frame without an FCS.
            txd     <= 8'h00;
            tx_en   <= 1'b0;
            tx_er   <= 1'b1;
            r_state <= StIfg;
          end
        end
        StPad: begin
          txd        <= 8'h00;
          tx_en      <= 1'b1;
          r_cnt      <= 16'd0;
          r_byte_cnt <= w_byte_cnt_inc;
          if (w_cnt_next >= MinLen17) r_state <= StFcs;
        end
        StFcs: begin
          tx_en <= 1'b1;
          r_cnt <= r_cnt + 16'd1;
          // The CRC is complete on the first FCS cycle; hold it for the other three bytes.
          case (r_cnt[1:0])
            2'd0:    begin txd <= w_fcs[7:0]; r_fcs <= w_fcs; end
            2'd1:    txd <= r_fcs[15:8];
            2'd2:    txd <= r_fcs[23:16];
            default: begin txd <= r_fcs[31:24]; r_cnt <= 16'd0; r_state <= StIfg; end
          endcase
        end
        StIfg: begin
          // IFG_LEN+1 cycles: the first still shows the last FCS byte on txd.
          txd   <= 8'h00;
          tx_en <= 1'b0;
          r_cnt <= r_cnt + 16'd1;
          if (r_cnt >= IfgLen16) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
